// File: rtl/cr_kme_fifo_pkg.sv
// Shared types and widths for the KME staging FIFO write-side feeder.
package cr_kme_fifo_pkg;

   localparam int KME_FIFO_DATA_W = 611;
   localparam int KME_FIFO_CNT_W  = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2,
      ERR   = 2'd3
   } feeder_state_e;

endpackage

// File: rtl/cr_kme_sat_cnt.sv
// Free-running event counter; sat=1 holds at all-ones, sat=0 wraps.
module cr_kme_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         sat,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && !(sat && (&cnt_q))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/cr_kme_fifo_feeder.sv
// Write-side producer for the KME staging FIFO: 2-entry skid buffer, stall
// handling, write/stall counters and a sticky overflow error state.
module cr_kme_fifo_feeder
   import cr_kme_fifo_pkg::*;
#(
   parameter int DATA_W = KME_FIFO_DATA_W,
   parameter int CNT_W  = KME_FIFO_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] fifo_in,
   output logic              fifo_in_valid,
   input  logic              fifo_in_stall,
   input  logic              fifo_overflow,
   output logic              err_overflow,
   output logic [CNT_W-1:0]  words_written,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [1:0]        dbg_state
);

   // Handshake: a word moves upstream->feeder when in_valid & in_ready, and
   // feeder->FIFO when fifo_in_valid (already qualified by ~fifo_in_stall).
   feeder_state_e     state_q, state_d;
   logic [DATA_W-1:0] odata_q, odata_d;
   logic [DATA_W-1:0] sdata_q, sdata_d;
   logic              in_ready_q, in_ready_d;
   logic              err_q, err_d;
   logic              ovld;
   logic              accept;
   logic              push;

   assign ovld   = (state_q == ONE) || (state_q == TWO);
   assign accept = in_valid & in_ready_q;
   // Only combinational path to the FIFO; rst blocks a write in the reset cycle.
   assign push   = ovld & ~fifo_in_stall & ~rst;

   always_comb begin
      state_d = state_q;
      odata_d = odata_q;
      sdata_d = sdata_q;
      err_d   = err_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               odata_d = in_data;
            end
         end
         ONE: begin
            if (accept && push) begin
               odata_d = in_data;
            end else if (accept) begin
               state_d = TWO;
               sdata_d = in_data;
            end else if (push) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (push) begin
               state_d = ONE;
               odata_d = sdata_q;
            end
         end
         ERR: begin
            state_d = ERR;
         end
      endcase
      if (fifo_overflow) begin
         state_d = ERR;
         err_d   = 1'b1;
      end
      in_ready_d = (state_d != TWO) && (state_d != ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         odata_q    <= '0;
         sdata_q    <= '0;
         in_ready_q <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         odata_q    <= odata_d;
         sdata_q    <= sdata_d;
         in_ready_q <= in_ready_d;
         err_q      <= err_d;
      end
   end

   // ovld is false in ERR, so both counters freeze there without extra gating.
   cr_kme_sat_cnt #(.W(CNT_W)) u_words_cnt (
      .clk (clk),
      .rst (rst),
      .en  (push),
      .sat (1'b0),
      .cnt (words_written)
   );

   cr_kme_sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .en  (ovld & fifo_in_stall),
      .sat (1'b1),
      .cnt (stall_cycles)
   );

   assign in_ready      = in_ready_q;
   assign fifo_in       = odata_q;
   assign fifo_in_valid = push;
   assign err_overflow  = err_q;
   assign dbg_state     = state_q;

endmodule

// File: doc/cr_kme_fifo_feeder.md
Name: cr_kme_fifo_feeder

Overview:
- Write-side producer for the KME 611-bit staging FIFO wrapper.
- Accepts words from an upstream valid/ready source and drives the FIFO's fifo_in/fifo_in_valid.
- Honours fifo_in_stall and never writes while it is high.
- Registered 2-entry skid stage decouples upstream ready from downstream stall. Word and stall-cycle counters, plus a sticky error state on FIFO overflow.

Parameters:
DATA_W, 611, payload width; must match the FIFO data width.
CNT_W, 16, width of the written-word and stall-cycle counters.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
in_data  input  DATA_W  upstream word
in_valid  input  1  upstream word present
in_ready  output  1  feeder can accept; registered
fifo_in  output  DATA_W  word to FIFO; equals output-register contents
fifo_in_valid  output  1  FIFO write enable
fifo_in_stall  input  1  FIFO cannot accept this cycle
fifo_overflow  input  1  FIFO overflow pulse
err_overflow  output  1  sticky; set when overflow is seen
words_written  output  CNT_W  count of FIFO writes; wraps
stall_cycles  output  CNT_W  cycles with a word pending under stall; saturates at all-ones

Behaviour:
- Reset (rst sampled high at posedge):
  - all state cleared; state=EMPTY
  - in_ready=1 on the cycle after reset; fifo_in_valid=0; fifo_in=0
  - err_overflow=0; both counters=0
  - reset mid-transfer discards buffered words, with no FIFO write in the reset cycle
- Accept = in_valid & in_ready. Push = ovld & ~fifo_in_stall & state!=ERR.
- fifo_in_valid = Push. This is the only combinational path (stall -> valid). All else is registered.
- Storage: output register (ovld, odata) and skid register (svld, sdata).
- States:
  - EMPTY (ovld=0, svld=0)
  - ONE (ovld=1, svld=0)
  - TWO (ovld=1, svld=1)
  - ERR
- Transitions:
  - EMPTY: Accept -> ONE, odata<=in_data. Latency from accept to fifo_in_valid is 1 cycle.
  - ONE:
    - Accept & Push -> ONE, odata<=in_data
    - Accept & ~Push -> TWO, sdata<=in_data
    - ~Accept & Push -> EMPTY
    - otherwise hold
  - TWO:
    - Push -> ONE, odata<=sdata
    - ~Push -> hold
    - Accept is impossible here (in_ready=0)
- in_ready next = (next state != TWO) & (next state != ERR).
- Ordering is strict FIFO. No word is dropped or duplicated.
- Stall handling:
  - fifo_in_stall high holds odata/sdata stable; fifo_in is unchanged while valid is suppressed.
  - stall_cycles increments each cycle with ovld & fifo_in_stall, saturating.
- words_written increments on Push and wraps modulo 2^CNT_W.
- Overflow handling:
  - fifo_overflow=1 in any state -> ERR next cycle; err_overflow<=1.
  - ERR: in_ready=0, fifo_in_valid=0, counters frozen. Exit only via rst.
  - Overflow has priority over any simultaneous Accept/Push in that cycle. The Push in that cycle still occurs, because valid is combinational, and is counted.
- Upstream protocol: in_data must be held while in_valid & ~in_ready. The feeder does not check this.

Decomposition:
- Shared package cr_kme_fifo_pkg:
  - state enum {EMPTY, ONE, TWO, ERR}
  - constant KME_FIFO_DATA_W=611
  - counter width constant
- Optional sub-module cr_kme_sat_cnt: saturating/wrapping counter with a mode select, used twice.

Test Plan:
- Reset then a stream of 8 words, stall=0 -> 8 writes in order; first fifo_in_valid one cycle after first accept; words_written=8; in_ready stays 1.
- Word A accepted, stall=1 for 5 cycles, B offered -> B accepted into skid; in_ready=0; fifo_in_valid=0 throughout; stall_cycles=5; on release, A then B written back-to-back.
- Stall pulses on alternating cycles with continuous in_valid, 20 words -> all 20 written in order, never under stall; in_ready low only when TWO.
- fifo_overflow pulse while state=TWO -> err_overflow=1 next cycle; in_ready=0; no further fifo_in_valid; counters frozen until rst.
- rst asserted while TWO -> next cycle state=EMPTY, in_ready=1, counters=0; buffered words never written.
- Preload words_written=0xFFFF via 65535 writes, then 1 more -> wraps to 0. Hold a stall for 70000 cycles -> stall_cycles=0xFFFF.
